// File: rtl/led_blink_engine_if.sv
// Configuration write port of the LED blink engine.
// The board controller drives the master side; the engine samples the slave side.
interface led_blink_engine_if #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  logic                      cfg_we;
  logic [$clog2(NUM_CH)-1:0] cfg_ch;
  logic [1:0]                cfg_mode;
  logic [CNT_W-1:0]          cfg_half;
  logic [BURST_W-1:0]        cfg_count;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count
  );
endinterface

// File: rtl/led_blink_engine.sv
// Multi-channel LED driver with OFF / ON / BLINK / BURST modes, a shared tick
// prescaler and a runtime configuration write port.
module led_blink_engine #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 11,
  parameter int BURST_W  = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  led_blink_engine_if.slave cfg,
  output logic [NUM_CH-1:0] LEDG,
  output logic [NUM_CH-1:0] busy
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  logic [PS_W-1:0] pre_q;
  logic [PS_W-1:0] pre_d;
  logic            tick;

  // Free-running prescaler; config writes never touch it.
  always_comb begin
    tick  = (pre_q == PS_W'(PRESCALE - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mode_e              mode_q;
    logic [CNT_W-1:0]   half_q;
    logic [CNT_W-1:0]   phase_q;
    logic [BURST_W-1:0] rem_q;
    logic               led_q;
    logic               busy_q;
    logic               hit;
    logic               run;
    logic               wrap;

    // Out-of-range channel numbers match no channel, so such writes vanish.
    assign hit  = cfg.cfg_we && (cfg.cfg_ch == CH_W'(c));
    assign run  = tick && ((mode_q == MODE_BLINK) || (mode_q == MODE_BURST));
    assign wrap = (phase_q == half_q - 1'b1);

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        mode_q  <= MODE_OFF;
        half_q  <= '0;
        phase_q <= '0;
        rem_q   <= '0;
        led_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (hit) begin
        half_q  <= (cfg.cfg_half == '0) ? CNT_W'(1) : cfg.cfg_half;
        phase_q <= '0;
        rem_q   <= cfg.cfg_count;
        case (mode_e'(cfg.cfg_mode))
          MODE_OFF: begin
            mode_q <= MODE_OFF;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
          end
          MODE_ON: begin
            mode_q <= MODE_ON;
            led_q  <= 1'b1;
            busy_q <= 1'b0;
          end
          MODE_BLINK: begin
            mode_q <= MODE_BLINK;
            led_q  <= 1'b1;
            busy_q <= 1'b0;
          end
          MODE_BURST: begin
            // An empty burst collapses straight to idle.
            if (cfg.cfg_count != '0) begin
              mode_q <= MODE_BURST;
              led_q  <= 1'b1;
              busy_q <= 1'b1;
            end else begin
              mode_q <= MODE_OFF;
              led_q  <= 1'b0;
              busy_q <= 1'b0;
            end
          end
        endcase
      end else if (run) begin
        if (wrap) begin
          phase_q <= '0;
          led_q   <= ~led_q;
          // Falling edge of a burst pulse consumes one pulse.
          if ((mode_q == MODE_BURST) && led_q) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == BURST_W'(1)) begin
              mode_q <= MODE_OFF;
              busy_q <= 1'b0;
            end
          end
        end else begin
          phase_q <= phase_q + 1'b1;
        end
      end
    end

    assign LEDG[c] = led_q;
    assign busy[c] = busy_q;
  end

endmodule

// File: tb/tb_led_blink_engine.sv
// Directed, table-driven bench for led_blink_engine with three channels and
// an 11-cycle tick; expected LED/busy patterns are hand-derived.
module tb_led_blink_engine;
  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 16;
  localparam int PRESCALE = 11;
  localparam int BURST_W  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ledg;
  logic [2:0]  busy;

  led_blink_engine_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_if ();

  led_blink_engine #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(PRESCALE), .BURST_W(BURST_W)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .cfg     (cfg_if),
    .LEDG    (ledg),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [1:0]  ch;
    logic [1:0]  mode;
    logic [15:0] half;
    logic [7:0]  cnt;
    int          adv;
    logic [2:0]  led;
    logic [2:0]  bsy;
  } vec_t;

  vec_t tbl[$];
  int   applied     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [2:0] el, input logic [2:0] eb);
    applied++;
    if (ledg !== el || busy !== eb) begin
      miscompares++;
      $display("FAIL %s: LEDG=%b busy=%b, expected LEDG=%b busy=%b", name, ledg, busy, el, eb);
    end
  endtask

  task automatic drive(input bit we, input logic [1:0] ch, input logic [1:0] mode,
                       input logic [15:0] half, input logic [7:0] cnt);
    cfg_if.cfg_we    = we;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_mode  = mode;
    cfg_if.cfg_half  = half;
    cfg_if.cfg_count = cnt;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.we, v.ch, v.mode, v.half, v.cnt);
    @(posedge clk);
    #1;
    cfg_if.cfg_we = 1'b0;
    step(v.adv);
    check($sformatf("vec%0d", idx), v.led, v.bsy);
  endtask

  initial begin
    // Comments give the edge count since reset release at the check point.
    tbl.push_back('{1'b1, 2'd0, 2'd2, 16'd1, 8'd0,  0, 3'b001, 3'b000}); // 1   ch0 BLINK h1
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  8, 3'b001, 3'b000}); // 10
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  0, 3'b000, 3'b000}); // 11  tick
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  9, 3'b000, 3'b000}); // 21
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  0, 3'b001, 3'b000}); // 22
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  9, 3'b001, 3'b000}); // 32
    tbl.push_back('{1'b1, 2'd1, 2'd3, 16'd2, 8'd3,  0, 3'b010, 3'b010}); // 33  ch1 BURST h2 c3
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 20, 3'b011, 3'b010}); // 54
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  0, 3'b000, 3'b010}); // 55
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 20, 3'b001, 3'b010}); // 76
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  0, 3'b010, 3'b010}); // 77
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 21, 3'b000, 3'b010}); // 99
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 21, 3'b010, 3'b010}); // 121
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 20, 3'b011, 3'b010}); // 142
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  0, 3'b000, 3'b000}); // 143 burst done
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 32, 3'b001, 3'b000}); // 176
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  9, 3'b001, 3'b000}); // 186
    tbl.push_back('{1'b1, 2'd0, 2'd2, 16'd0, 8'd0,  0, 3'b001, 3'b000}); // 187 ch0 BLINK h0 on tick
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  9, 3'b001, 3'b000}); // 197
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  0, 3'b000, 3'b000}); // 198
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 10, 3'b001, 3'b000}); // 209
    tbl.push_back('{1'b1, 2'd1, 2'd1, 16'd0, 8'd0,  0, 3'b011, 3'b000}); // 210 ch1 ON
    tbl.push_back('{1'b1, 2'd1, 2'd3, 16'd5, 8'd0,  0, 3'b001, 3'b000}); // 211 ch1 BURST c0
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 30, 3'b000, 3'b000}); // 242
    tbl.push_back('{1'b1, 2'd1, 2'd3, 16'd1, 8'd5,  0, 3'b010, 3'b010}); // 243 ch1 BURST h1 c5
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  9, 3'b001, 3'b010}); // 253
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 10, 3'b010, 3'b010}); // 264
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 11, 3'b001, 3'b010}); // 276 two pulses done
    tbl.push_back('{1'b1, 2'd1, 2'd1, 16'd0, 8'd0,  0, 3'b011, 3'b000}); // 277 abort to ON
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 20, 3'b011, 3'b000}); // 298
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  9, 3'b010, 3'b000}); // 308
    tbl.push_back('{1'b1, 2'd3, 2'd1, 16'd4, 8'd0,  0, 3'b010, 3'b000}); // 309 ch3 ON ignored
    tbl.push_back('{1'b1, 2'd3, 2'd0, 16'd0, 8'd0,  0, 3'b010, 3'b000}); // 310 ch3 OFF ignored
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  7, 3'b010, 3'b000}); // 318
    tbl.push_back('{1'b1, 2'd2, 2'd2, 16'd3, 8'd0,  0, 3'b111, 3'b000}); // 319 ch2 BLINK h3 on tick
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0, 31, 3'b111, 3'b000}); // 351
    tbl.push_back('{1'b0, 2'd0, 2'd0, 16'd0, 8'd0,  0, 3'b010, 3'b000}); // 352

    drive(1'b0, 2'd0, 2'd0, 16'd0, 8'd0);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    check("reset_state", 3'b000, 3'b000);

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset in the middle of blinking, with a competing write on the first edge.
    rst = 1'b1;
    drive(1'b1, 2'd0, 2'd1, 16'd0, 8'd0);
    step(1);
    cfg_if.cfg_we = 1'b0;
    check("reset_edge", 3'b000, 3'b000);
    step(2);
    rst = 1'b0;
    step(40);
    check("reset_hold", 3'b000, 3'b000);

    // Single-pulse burst after reset: prescaler restarted, next tick at edge 44.
    drive(1'b1, 2'd1, 2'd3, 16'd1, 8'd1);
    step(1);
    cfg_if.cfg_we = 1'b0;
    check("post_reset_burst", 3'b010, 3'b010);
    step(2);
    check("burst1_before_tick", 3'b010, 3'b010);
    step(1);
    check("burst1_done", 3'b000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
